// File: rtl/reflet_rmw_sequencer_if.sv
// rtl/reflet_rmw_sequencer_if.sv - request/response and RAM bus bundle for the RMW sequencer
`timescale 1ns/1ps
interface reflet_rmw_sequencer_if #(
    parameter int wordsize = 16,
    parameter int addrsize = 16
);
    logic                req_valid;
    logic                req_ready;
    logic                req_write;
    logic [1:0]          req_size;
    logic [addrsize-1:0] req_addr;
    logic [wordsize-1:0] req_wdata;
    logic                resp_valid;
    logic [wordsize-1:0] resp_rdata;
    logic                busy;
    logic [addrsize-1:0] ram_addr;
    logic                ram_write_en;
    logic [wordsize-1:0] ram_data_out;
    logic [wordsize-1:0] ram_data_in;

    // Core/RAM side: issues requests and returns RAM read data
    modport master (
        output req_valid, req_write, req_size, req_addr, req_wdata, ram_data_in,
        input  req_ready, resp_valid, resp_rdata, busy, ram_addr, ram_write_en, ram_data_out
    );

    // Sequencer side
    modport slave (
        input  req_valid, req_write, req_size, req_addr, req_wdata, ram_data_in,
        output req_ready, resp_valid, resp_rdata, busy, ram_addr, ram_write_en, ram_data_out
    );
endinterface

// File: rtl/reflet_rmw_sequencer.sv
// rtl/reflet_rmw_sequencer.sv - load/store sequencer with read-modify-write for reduced-width stores
`timescale 1ns/1ps
module reflet_rmw_sequencer #(
    parameter int wordsize     = 16,
    parameter int addrsize     = 16,
    parameter int read_latency = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    reflet_rmw_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [3:0] last_count = 4'(read_latency);

    // A size narrower than the word needs a merge; anything else is a full-word access
    function automatic logic is_reduced(input logic [1:0] size);
        logic r;
        case (size)
            2'b01:   r = (wordsize > 32);
            2'b10:   r = (wordsize > 16);
            2'b11:   r = (wordsize > 8);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Ones in the low n bits of the word; only meaningful when the size is reduced
    function automatic logic [wordsize-1:0] low_mask(input logic [1:0] size);
        logic [7:0] n;
        case (size)
            2'b01:   n = 8'd32;
            2'b10:   n = 8'd16;
            2'b11:   n = 8'd8;
            default: n = 8'd0;
        endcase
        return ~({wordsize{1'b1}} << n);
    endfunction

    state_t              state;
    state_t              state_next;
    logic                write_q;
    logic [1:0]          size_q;
    logic [addrsize-1:0] addr_q;
    logic [wordsize-1:0] wdata_q;
    logic [wordsize-1:0] captured_q;
    logic [3:0]          count_q;

    logic                accept;
    logic                count_done;
    logic                reduced_q;
    logic [wordsize-1:0] mask_q;
    logic [wordsize-1:0] merged;

    assign accept     = bus.req_valid && (state == IDLE);
    assign count_done = (count_q == last_count);
    assign reduced_q  = is_reduced(size_q);
    assign mask_q     = low_mask(size_q);
    assign merged     = (captured_q & ~mask_q) | (wdata_q & mask_q);

    // State register; reset drops any operation in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and bus outputs
    always_comb begin
        state_next       = state;
        bus.req_ready    = 1'b0;
        bus.busy         = 1'b1;
        bus.resp_valid   = 1'b0;
        bus.resp_rdata   = '0;
        bus.ram_addr     = '0;
        bus.ram_write_en = 1'b0;
        bus.ram_data_out = '0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                bus.busy      = 1'b0;
                if (accept) begin
                    if (bus.req_write && !is_reduced(bus.req_size)) begin
                        state_next = WRITE;
                    end else begin
                        state_next = READ;
                    end
                end
            end
            READ: begin
                bus.ram_addr = addr_q;
                if (count_done) begin
                    state_next = write_q ? WRITE : RESP;
                end
            end
            WRITE: begin
                bus.ram_addr     = addr_q;
                bus.ram_write_en = 1'b1;
                bus.ram_data_out = reduced_q ? merged : wdata_q;
                state_next       = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                if (!write_q) begin
                    bus.resp_rdata = reduced_q ? (captured_q & mask_q) : captured_q;
                end
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request latch, read-wait counter and captured RAM word
    always_ff @(posedge clk) begin
        if (reset) begin
            write_q    <= 1'b0;
            size_q     <= 2'b00;
            addr_q     <= '0;
            wdata_q    <= '0;
            captured_q <= '0;
            count_q    <= 4'd0;
        end else begin
            if (accept) begin
                write_q <= bus.req_write;
                size_q  <= bus.req_size;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            if (state == READ && count_done) begin
                captured_q <= bus.ram_data_in;
            end
            count_q <= (state == READ && !count_done) ? count_q + 4'd1 : 4'd0;
        end
    end

endmodule
